uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive end of the project UART link. Accepts the 8N1 serial stream that uart_tx2
//  produces. Assembles the received bytes and queues them in a small FIFO.
//  Presents each byte to the consumer on a valid/ready handshake.
//  Runs on the same divided bit clock that drives the transmitter; samples at mid-bit.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; even, >=4
//  FIFO_DEPTH    4   byte entries; power of 2, >=2
//  SYNC_STAGES   2   flops in the data_in synchroniser; >=2
// PORTS
//  clk         in   1              bit-rate clock; all logic on the rising edge
//  rst_n       in   1              asynchronous, active-low reset
//  data_in     in   1              serial line; idles high
//  out_data    out  8              byte at the FIFO head
//  out_valid   out  1              FIFO not empty
//  out_ready   in   1              consumer takes out_data when out_valid&&out_ready
//  fifo_count  out  clog2(D)+1     current number of entries
//  busy        out  1              FSM is not in IDLE
//  frame_err   out  1              1-cycle pulse: stop bit sampled low
//  overflow    out  1              1-cycle pulse: good byte dropped because FIFO full
//  parity_err  out  1              1-cycle pulse: parity mismatch (tied 0 unless macro)
// BEHAVIOUR
//  Reset: one clock, async active-low. On reset:
//    - all outputs 0; out_data=8'h00
//    - synchroniser flops=1; FSM=IDLE; FIFO empty
//    - a frame in progress is abandoned, with no partial push
//  data_in passes through SYNC_STAGES flops; only the synchronised value (rxs) is used.
//  Bit counter: bcnt, 16-bit.
//  FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
//   IDLE:      rxs==0 -> START, bcnt=0.
//   START:     bcnt increments. At bcnt==CLKS_PER_BIT/2-1:
//                rxs==0 -> DATA, bcnt=0, bitidx=0
//                rxs==1 -> IDLE (glitch rejected, no flags)
//   DATA:      sample rxs at bcnt==CLKS_PER_BIT-1; shift LSB-first: sh={rxs,sh[7:1]}; bcnt=0.
//              After bitidx 7 -> STOP (or PARITY with macro).
//   STOP:      sample at bcnt==CLKS_PER_BIT-1.
//                rxs==1 -> push sh; go to IDLE
//                rxs==0 -> frame_err=1 for 1 cycle; byte discarded; -> WAIT_HIGH
//   WAIT_HIGH: stay until rxs==1, then -> IDLE. A held-low break gives exactly 1 frame_err.
//  FIFO:
//   - out_data/out_valid reflect the head. out_valid rises the cycle after the push.
//   - Pop when out_valid&&out_ready.
//   - Simultaneous push+pop: both take effect; count is unchanged, including when full.
//   - Push when full and no pop: byte dropped, overflow pulses 1 cycle, contents intact.
//   - Pop when empty: ignored.
//   - Read/write pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
//  End-of-stop to IDLE is 0.5 bit early, so back-to-back frames from uart_tx2 are never missed.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - PARITY state after DATA samples 1 even-parity bit at bcnt==CLKS_PER_BIT-1.
//   - At STOP, if the stop bit is good but parity mismatched: parity_err pulses, byte dropped.
//   - Stop low takes precedence: frame_err only.
//  UART_RX_PARITY_EN undefined:
//   - No PARITY state; the frame is 10 bits.
//   - parity_err is held 0.
// TESTING (CLKS_PER_BIT=16, FIFO_DEPTH=4)
//  1. Serial 8'h48, out_ready=1 -> out_valid for 1 cycle with out_data=8'h48; no error pulses.
//  2. Bytes 21,43,65,87,A9 back-to-back, out_ready=0 -> fifo_count=4, one overflow pulse;
//     then drain -> 21,43,65,87 in order.
//  3. 6-cycle low glitch on idle line -> returns to IDLE; fifo_count=0; busy low again by cycle 10.
//  4. 8'hFF with stop bit low, then line low for 40 bits -> exactly one frame_err; nothing pushed;
//     next good 8'h5A received.
//  5. rst_n low mid-DATA of 8'h33 -> all outputs 0 at once; after release, 8'hC3 received intact.
//  6. (macro) 8'h07 sent with parity 0 -> parity_err pulse, not pushed; sent with parity 1 -> pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive end of the project UART link. Deserialises the 8N1 stream produced
//   by uart_tx2 (sampled at mid-bit on the shared bit-rate clock), queues each
//   good byte in a small FIFO and presents the head on a valid/ready handshake.
//
//   Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
//   between the data bits and the stop bit (11-bit frame). Without it the
//   frame is 10 bits and parity_err is held 0.
//
// Ports
//   clk         in   bit-rate clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   data_in     in   serial line, idles high
//   out_data    out  byte at the FIFO head (0 when empty)
//   out_valid   out  FIFO not empty
//   out_ready   in   consumer takes out_data when out_valid && out_ready
//   fifo_count  out  number of queued bytes, 0..FIFO_DEPTH
//   busy        out  receiver FSM not idle
//   frame_err   out  1-cycle pulse: stop bit sampled low
//   overflow    out  1-cycle pulse: good byte dropped, FIFO full
//   parity_err  out  1-cycle pulse: parity mismatch (0 without the macro)
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          data_in,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          parity_err
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  // ---------------------------------------------------------------------------
  // Input synchroniser; resets to the idle (high) line level so that reset
  // release never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  // NOTE: every clocked block uses non-blocking (<=) assignments so that all
  // flops update together from pre-edge values; blocking here would create
  // order-dependent simulation and mismatch the synthesised netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  logic [2:0]  state;
  logic [15:0] bcnt;
  logic [2:0]  bitidx;
  logic [7:0]  sh;
  logic        stop_sample;
  logic        par_bad;
  logic        push;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  // Even parity: data ones plus the parity bit must be even.
  assign par_bad = par_bit != (^sh);
`else
  assign par_bad = 1'b0;
`endif

  assign stop_sample = (state == S_STOP) && (bcnt == BIT_LAST);
  assign push        = stop_sample && rxs && !par_bad;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      bcnt   <= '0;
      bitidx <= '0;
      sh     <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            bcnt  <= '0;
          end
        end
        S_START: begin
          if (bcnt == HALF_LAST) begin
            // Still low at mid start bit: real frame. Otherwise a glitch.
            state  <= rxs ? S_IDLE : S_DATA;
            bcnt   <= '0;
            bitidx <= '0;
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end
        S_DATA: begin
          if (bcnt == BIT_LAST) begin
            sh     <= {rxs, sh[7:1]};
            bcnt   <= '0;
            bitidx <= bitidx + 3'd1;
            if (bitidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bcnt == BIT_LAST) begin
            par_bit <= rxs;
            bcnt    <= '0;
            state   <= S_STOP;
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end
`endif
        S_STOP: begin
          // Leaving at mid stop bit gives half a bit of slack before the next
          // start edge of a back-to-back frame.
          if (bcnt == BIT_LAST) begin
            bcnt  <= '0;
            state <= rxs ? S_IDLE : S_WAIT_HIGH;
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end
        S_WAIT_HIGH: begin
          // A held-low break produces one frame_err, then waits out the line.
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_en;

  assign full      = (fifo_count == (PW+1)'(FIFO_DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  // When full, a same-cycle pop frees the head slot, which is the write slot.
  assign wr_en     = push && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

  // NOTE: the storage array has no reset; out_data is gated by out_valid, so
  // stale entries are never visible and the array can map to plain RAM/flops
  // without a reset network.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      frame_err  <= stop_sample && !rxs;
      parity_err <= stop_sample && rxs && par_bad;
      overflow   <= push && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4). The bench
//   drives the serial line on falling edges; a monitor samples 1 ns after each
//   falling edge and tallies error pulses, valid/busy cycles and popped bytes.
//   Define UART_RX_PARITY_EN for both files to include the parity step.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_count;
  logic       busy, frame_err, overflow, parity_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vcyc = 0, bcyc = 0;
  logic [7:0] popped[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .busy(busy), .frame_err(frame_err),
    .overflow(overflow), .parity_err(parity_err)
  );

  // Monitor: values seen here are exactly those the DUT uses at the next edge.
  always begin
    @(negedge clk);
    #1;
    if (frame_err)  fe_cnt++;
    if (overflow)   ov_cnt++;
    if (parity_err) pe_cnt++;
    if (out_valid)  vcyc++;
    if (busy)       bcyc++;
    if (out_valid && out_ready) popped.push_back(out_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par) begin end
`endif
    send_bit(stop);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
  endtask

  task automatic idle(input int n);
    data_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int p0, v0, f0, o0, e0, b0;
  logic [7:0] exp_bytes [4];

  initial begin
    exp_bytes[0] = 8'h21; exp_bytes[1] = 8'h43;
    exp_bytes[2] = 8'h65; exp_bytes[3] = 8'h87;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_data",   32'(out_data),   32'h00);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_errs",       32'({frame_err, overflow, parity_err}), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // 1. Single byte, consumer ready
    out_ready = 1'b1;
    v0 = vcyc; p0 = popped.size(); f0 = fe_cnt; o0 = ov_cnt; e0 = pe_cnt;
    send_byte(8'h48);
    idle(20);
    check("t1_valid_cycles", 32'(vcyc - v0),           32'd1);
    check("t1_pop_count",    32'(popped.size() - p0),  32'd1);
    check("t1_byte",         32'(popped[p0]),          32'h48);
    check("t1_no_errs",      32'((fe_cnt - f0) + (ov_cnt - o0) + (pe_cnt - e0)), 32'd0);
    check("t1_fifo_empty",   32'(fifo_count),          32'd0);

    // 2. Five back-to-back bytes into a 4-deep FIFO, then drain
    out_ready = 1'b0;
    o0 = ov_cnt;
    send_byte(8'h21); send_byte(8'h43); send_byte(8'h65);
    send_byte(8'h87); send_byte(8'hA9);
    idle(20);
    check("t2_count_full", 32'(fifo_count),  32'd4);
    check("t2_overflow",   32'(ov_cnt - o0), 32'd1);
    check("t2_head",       32'(out_data),    32'h21);
    p0 = popped.size();
    out_ready = 1'b1;
    idle(10);
    check("t2_drain_count", 32'(popped.size() - p0), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_drain_%0d", i), 32'(popped[p0 + i]), 32'(exp_bytes[i]));
    check("t2_empty", 32'(fifo_count), 32'd0);

    // 3. Six-cycle low glitch: START lasts 8 cycles, then back to IDLE
    b0 = bcyc; f0 = fe_cnt;
    data_in = 1'b0;
    repeat (6) @(negedge clk);
    data_in = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_busy_cycles", 32'(bcyc - b0),   32'd8);
    check("t3_busy_low",    32'(busy),        32'd0);
    check("t3_fifo_empty",  32'(fifo_count),  32'd0);
    check("t3_no_ferr",     32'(fe_cnt - f0), 32'd0);

    // 4. 8'hFF with stop bit low, then a 40-bit break
    f0 = fe_cnt; p0 = popped.size();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0);
`endif
    data_in = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    idle(40);
    check("t4_one_ferr",   32'(fe_cnt - f0),          32'd1);
    check("t4_no_push",    32'(popped.size() - p0),   32'd0);
    check("t4_count",      32'(fifo_count),           32'd0);
    check("t4_busy_low",   32'(busy),                 32'd0);
    send_byte(8'h5A);
    idle(20);
    check("t4_next_count", 32'(popped.size() - p0),   32'd1);
    check("t4_next_byte",  32'(popped[p0]),           32'h5A);

    // 5. Reset in the middle of a frame
    out_ready = 1'b0;
    send_byte(8'h96);
    idle(5);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h33 >> i));
    check("t5_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid),  32'd0);
    check("t5_rst_data",  32'(out_data),   32'h00);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    check("t5_rst_busy",  32'(busy),       32'd0);
    check("t5_rst_errs",  32'({frame_err, overflow, parity_err}), 32'd0);
    data_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    check("t5_post_count", 32'(fifo_count), 32'd0);
    out_ready = 1'b1;
    p0 = popped.size();
    send_byte(8'hC3);
    idle(20);
    check("t5_c3_count", 32'(popped.size() - p0), 32'd1);
    check("t5_c3_byte",  32'(popped[p0]),         32'hC3);

`ifdef UART_RX_PARITY_EN
    // 6. 8'h07 has three ones: even parity bit is 1
    e0 = pe_cnt; p0 = popped.size();
    send_frame(8'h07, 1'b0, 1'b1);
    idle(20);
    check("t6_perr",       32'(pe_cnt - e0),         32'd1);
    check("t6_bad_drop",   32'(popped.size() - p0),  32'd0);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("t6_good_count", 32'(popped.size() - p0),  32'd1);
    check("t6_good_byte",  32'(popped[p0]),          32'h07);
    check("t6_no_more_perr", 32'(pe_cnt - e0),       32'd1);
`else
    check("t6_perr_tied", 32'(pe_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
